// File: rtl/tile_pkg.sv
// Shared types, board geometry and index helper for the tile frame buffer.
package tile_pkg;

  localparam int unsigned COLS     = 14;
  localparam int unsigned ROWS     = 10;
  localparam int unsigned QCOLS    = 7;
  localparam int unsigned QROWS    = 5;
  localparam int unsigned NTILES   = 140;
  localparam int unsigned WIN_BITS = 105;

  // Bit positions of the colour channels inside one tile.
  localparam int unsigned R = 0;
  localparam int unsigned G = 1;
  localparam int unsigned B = 2;

  typedef logic [2:0] rgb_t;
  typedef rgb_t [NTILES-1:0] bank_t;

  typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_e;

  // Flat raster index row*COLS+col; callers range-check first, so 8 bits never wrap.
  function automatic logic [7:0] tile_idx(input logic [3:0] row, input logic [3:0] col);
    return 8'(row) * 8'(COLS) + 8'(col);
  endfunction

endpackage

// File: rtl/tile_frame_buffer_if.sv
// Back-bank tile write bus: producer drives the tile, buffer answers with ready.
interface tile_frame_buffer_if;
  import tile_pkg::*;

  logic       wr_en;
  logic [3:0] wr_col;
  logic [3:0] wr_row;
  rgb_t       wr_rgb;
  logic       wr_ready;

  modport master (output wr_en, output wr_col, output wr_row, output wr_rgb, input wr_ready);
  modport slave  (input wr_en, input wr_col, input wr_row, input wr_rgb, output wr_ready);
endinterface

// File: rtl/tile_window_mux.sv
// Combinational selection of the 7x5 quadrant window out of one 14x10 bank.
module tile_window_mux import tile_pkg::*; (
  input  bank_t                tiles,
  input  logic [1:0]           quadrant,
  output logic [WIN_BITS-1:0]  window
);

  // Gather each window tile from its offset board position.
  always_comb begin
    window = '0;
    for (int unsigned r = 0; r < QROWS; r++) begin
      for (int unsigned c = 0; c < QCOLS; c++) begin
        window[3*(r*QCOLS+c) +: 3] =
          tiles[tile_idx(4'(r) + (quadrant[1] ? 4'(QROWS) : 4'd0),
                         4'(c) + (quadrant[0] ? 4'(QCOLS) : 4'd0))];
      end
    end
  end

endmodule

// File: rtl/tile_frame_buffer.sv
// Double-buffered tile store: writes and clears hit the back bank, the front
// bank's quadrant window is presented registered, banks swap on vsync fall.
module tile_frame_buffer import tile_pkg::*; #(
  parameter rgb_t CLR_RGB = 3'b000
) (
  input  logic                 clk,
  input  logic                 rst_btn,
  tile_frame_buffer_if.slave   wr,
  input  logic                 clr_req,
  input  logic                 swap_req,
  input  logic                 vsync,
  input  logic [1:0]           quadrant,
  output logic [WIN_BITS-1:0]  pixelMemory,
  output logic                 swap_done,
  output logic                 front_sel
);

  bank_t [1:0]         bank_q, bank_d;
  clr_state_e          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                front_q, front_d;
  logic                done_q, done_d;
  logic                vsync_q;
  logic [WIN_BITS-1:0] pix_q, pix_d;
  logic                wr_accept;
  logic                vsync_fall;
  logic                pend_eff;
  bank_t               front_tiles;

  assign wr.wr_ready = (state_q == ST_IDLE) & ~clr_req;

  // Write acceptance with range check ahead of indexing.
  always_comb begin
    wr_accept = wr.wr_en & wr.wr_ready &
                (wr.wr_col < 4'(COLS)) & (wr.wr_row < 4'(ROWS));
  end

  // Clear FSM and back-bank update; writes use the pre-swap back bank.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        bank_d[~front_q][cnt_q] = CLR_RGB;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(NTILES-1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (wr_accept) bank_d[~front_q][tile_idx(wr.wr_row, wr.wr_col)] = wr.wr_rgb;
  end

  // Pending swap resolved on a vsync falling edge once the clear is idle.
  always_comb begin
    vsync_fall = vsync_q & ~vsync;
    pend_eff   = pend_q | swap_req;
    front_d    = front_q;
    pend_d     = pend_eff;
    done_d     = 1'b0;
    if (vsync_fall && pend_eff && state_q == ST_IDLE) begin
      front_d = ~front_q;
      pend_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  // Front bank selection feeding the window mux.
  always_comb begin
    front_tiles = bank_q[front_q];
  end

  tile_window_mux u_win (
    .tiles    (front_tiles),
    .quadrant (quadrant),
    .window   (pix_d)
  );

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_btn) begin
      bank_q  <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      front_q <= 1'b0;
      done_q  <= 1'b0;
      vsync_q <= 1'b1;
      pix_q   <= '0;
    end else begin
      bank_q  <= bank_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      front_q <= front_d;
      done_q  <= done_d;
      vsync_q <= vsync;
      pix_q   <= pix_d;
    end
  end

  assign pixelMemory = pix_q;
  assign swap_done   = done_q;
  assign front_sel   = front_q;

endmodule
